uart_rx_pkt_ctrl: RTL and testbench

//  Controller that sequences one uart_reciever instance: generates its 16x-oversample clken, takes bytes via rdy/rdy_clr,

---
 rtl/uart_pkt_pkg.sv | 18 +
 rtl/uart_baud_gen.sv | 25 ++
 rtl/uart_rx_pkt_ctrl.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared constants and types for the UART packet receive controller.
package uart_pkt_pkg;

    localparam logic [7:0] SOF = 8'h7E;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CSUM    = 2'd3
    } pkt_state_t;

    localparam logic [1:0] ERR_LEN  = 2'd0;
    localparam logic [1:0] ERR_CSUM = 2'd1;
    localparam logic [1:0] ERR_OVR  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage

// File: rtl/uart_baud_gen.sv
// 16x-oversample enable generator: one-cycle clken every baud_div+1 clocks.
module uart_baud_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] baud_div,
    output logic        clken
);

    logic [15:0] cnt;
    logic [15:0] cnt_nxt;

    // baud_div is only sampled on reload, so a change never shortens a period in flight
    assign cnt_nxt = (cnt == 16'd0) ? baud_div : cnt - 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 16'd0;
            clken <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            clken <= (cnt_nxt == 16'd0);
        end
    end

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Sequences a UART receiver: byte intake, SOF/LEN/payload/XOR-checksum parsing, payload FIFO.
// Optional inter-byte timeout enabled by defining UART_RX_PKT_TIMEOUT_EN.
module uart_rx_pkt_ctrl
    import uart_pkt_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int MAX_LEN       = 16,
    parameter int TIMEOUT_TICKS = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] baud_div,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        rx_rdy_clr,
    output logic        rx_clken,
    output logic        m_valid,
    output logic [7:0]  m_data,
    output logic        m_last,
    input  logic        m_ready,
    output logic        pkt_ok,
    output logic        pkt_err,
    output logic [1:0]  err_code,
    output logic        overrun,
    input  logic        status_clr
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);

    uart_baud_gen u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_div (baud_div),
        .clken    (rx_clken)
    );

    // receiver drops rdy one cycle after seeing clr, so blank two cycles
    logic clr_d, take;
    assign take = rx_rdy && !rx_rdy_clr && !clr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_rdy_clr <= 1'b0;
            clr_d      <= 1'b0;
        end else begin
            rx_rdy_clr <= take;
            clr_d      <= rx_rdy_clr;
        end
    end

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign m_valid = !empty;
    assign m_data  = empty ? 8'h00 : mem[rd_ptr][7:0];
    assign m_last  = empty ? 1'b0  : mem[rd_ptr][8];
    assign pop     = m_valid && m_ready;

    pkt_state_t state, state_nxt;
    logic [7:0] cnt, cnt_nxt, csum, csum_nxt;
    logic       ok_nxt, err_nxt, ovr_set, tmo_hit;
    logic [1:0] code_nxt;

`ifdef UART_RX_PKT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    logic [TW-1:0] tmo_cnt;
    assign tmo_hit = (state != HUNT) && (tmo_cnt == TW'(TIMEOUT_TICKS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    tmo_cnt <= '0;
        else if (take || state == HUNT) tmo_cnt <= '0;
        else if (rx_clken && !tmo_hit) tmo_cnt <= tmo_cnt + TW'(1);
    end
`else
    logic unused_tmo;
    assign tmo_hit    = 1'b0;
    assign unused_tmo = ^{TIMEOUT_TICKS, ERR_TMO};
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        csum_nxt  = csum;
        push      = 1'b0;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        code_nxt  = 2'd0;
        ovr_set   = 1'b0;
        if (take) begin
            case (state)
                HUNT: if (rx_data == SOF) begin
                    state_nxt = LEN;
                    csum_nxt  = 8'h00;
                end
                LEN: if (rx_data == 8'h00 || rx_data > MAX_LEN_B) begin
                    err_nxt   = 1'b1;
                    code_nxt  = ERR_LEN;
                    state_nxt = HUNT;
                end else begin
                    cnt_nxt   = rx_data;
                    csum_nxt  = rx_data;
                    state_nxt = PAYLOAD;
                end
                // full is judged before any same-cycle pop
                PAYLOAD: if (full) begin
                    err_nxt   = 1'b1;
                    code_nxt  = ERR_OVR;
                    ovr_set   = 1'b1;
                    state_nxt = HUNT;
                end else begin
                    push     = 1'b1;
                    csum_nxt = csum ^ rx_data;
                    cnt_nxt  = cnt - 8'd1;
                    if (cnt == 8'd1) state_nxt = CSUM;
                end
                CSUM: begin
                    if (rx_data == csum) ok_nxt = 1'b1;
                    else begin
                        err_nxt  = 1'b1;
                        code_nxt = ERR_CSUM;
                    end
                    state_nxt = HUNT;
                end
                default: state_nxt = HUNT;
            endcase
        end else if (tmo_hit) begin
            err_nxt   = 1'b1;
            code_nxt  = ERR_TMO;
            state_nxt = HUNT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            cnt      <= 8'h00;
            csum     <= 8'h00;
            pkt_ok   <= 1'b0;
            pkt_err  <= 1'b0;
            err_code <= 2'd0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            csum     <= csum_nxt;
            pkt_ok   <= ok_nxt;
            pkt_err  <= err_nxt;
            err_code <= code_nxt;
            if (ovr_set)         overrun <= 1'b1;
            else if (status_clr) overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cnt == 8'd1, rx_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
        end
    end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Scoreboard bench for uart_rx_pkt_ctrl: directed packets, expected bytes/status queued, negedge monitor checks.
`timescale 1ns/1ps
module tb_uart_rx_pkt_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] baud_div = 16'd3;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_rdy_clr, rx_clken, m_valid, m_last, pkt_ok, pkt_err, overrun;
    logic [7:0]  m_data;
    logic [1:0]  err_code;
    logic        m_ready = 1'b0;
    logic        status_clr = 1'b0;

    int checks = 0, errors = 0, sent = 0, clr_seen = 0;
    logic [8:0] exp_b[$];
    logic [2:0] exp_s[$];

    always #5 clk = ~clk;

    uart_rx_pkt_ctrl #(.FIFO_DEPTH(4), .MAX_LEN(16), .TIMEOUT_TICKS(8)) dut (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .rx_rdy_clr(rx_rdy_clr), .rx_clken(rx_clken), .m_valid(m_valid), .m_data(m_data),
        .m_last(m_last), .m_ready(m_ready), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
        .err_code(err_code), .overrun(overrun), .status_clr(status_clr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // receiver model: rdy held until clr seen, then dropped one cycle late
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data = b;
        rx_rdy  = 1'b1;
        sent++;
        while (!rx_rdy_clr && n < 20) begin @(posedge clk); #1; n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL rdy_clr_timeout act=0 exp=1");
        end
        idle(1);
        rx_rdy = 1'b0;
        idle(2);
    endtask

    task automatic eb(input logic last, input logic [7:0] d);
        exp_b.push_back({last, d});
    endtask

    always @(negedge clk) begin
        logic [8:0] e9;
        logic [2:0] e3, o3;
        if (rst_n) begin
            if (rx_rdy_clr) clr_seen++;
            if (m_valid && m_ready) begin
                if (exp_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL byte_unexpected act=%0h exp=none", {m_last, m_data});
                end else begin
                    e9 = exp_b.pop_front();
                    chk("payload", {23'd0, m_last, m_data}, {23'd0, e9});
                end
            end
            if (pkt_ok || pkt_err) begin
                chk("ok_err_excl", {31'd0, pkt_ok & pkt_err}, 32'd0);
                o3 = pkt_ok ? 3'b100 : {1'b0, err_code};
                if (exp_s.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL status_unexpected act=%0h exp=none", o3);
                end else begin
                    e3 = exp_s.pop_front();
                    chk("status", {29'd0, o3}, {29'd0, e3});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=done");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_clken", {31'd0, rx_clken}, 32'd0);
        chk("rst_rdy_clr", {31'd0, rx_rdy_clr}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", {23'd0, m_last, m_data}, 32'd0);
        chk("rst_status", {27'd0, pkt_ok, pkt_err, err_code, overrun}, 32'd0);
        rst_n = 1'b1;

        // baud_div=3: clken after edges 4,8,12; then baud_div=0 from next reload
        for (int k = 1; k <= 12; k++) begin
            idle(1);
            chk("clken_div3", {31'd0, rx_clken}, (k % 4 == 0) ? 32'd1 : 32'd0);
        end
        baud_div = 16'd0;
        for (int k = 13; k <= 16; k++) begin
            idle(1);
            chk("clken_div0", {31'd0, rx_clken}, 32'd1);
        end

        m_ready = 1'b1;
        // good packet: csum 02^A5^5A = FD
        eb(0, 8'hA5); eb(1, 8'h5A); exp_s.push_back(3'b100);
        send_byte(8'h7E); send_byte(8'h02); send_byte(8'hA5); send_byte(8'h5A); send_byte(8'hFD);
        idle(4);

        // bad checksum
        eb(0, 8'hA5); eb(1, 8'h5A); exp_s.push_back({1'b0, 2'd1});
        send_byte(8'h7E); send_byte(8'h02); send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h00);
        idle(4);

        // junk before SOF, LEN=0, then LEN=17
        exp_s.push_back({1'b0, 2'd0}); exp_s.push_back({1'b0, 2'd0});
        send_byte(8'h11); send_byte(8'h7E); send_byte(8'h00);
        send_byte(8'h7E); send_byte(8'h11);
        idle(4);

        // SOF value as payload: csum 02^7E^7E = 02
        eb(0, 8'h7E); eb(1, 8'h7E); exp_s.push_back(3'b100);
        send_byte(8'h7E); send_byte(8'h02); send_byte(8'h7E); send_byte(8'h7E); send_byte(8'h02);
        idle(4);

        // LEN=16 boundary, payload 01..10: XOR of 01..10 is 10, ^LEN(10) gives 00
        exp_s.push_back(3'b100);
        send_byte(8'h7E); send_byte(8'h10);
        for (int i = 1; i <= 16; i++) begin
            eb(i == 16, 8'(i));
            send_byte(8'(i));
        end
        send_byte(8'h00);
        idle(4);

        // overrun: consumer stalled, 5th payload byte has no room
        m_ready = 1'b0;
        exp_s.push_back({1'b0, 2'd2});
        send_byte(8'h7E); send_byte(8'h06);
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        idle(2);
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        chk("ovr_fifo_held", {31'd0, m_valid}, 32'd1);
        idle(5);
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);
        status_clr = 1'b1;
        idle(1);
        status_clr = 1'b0;
        chk("ovr_clear", {31'd0, overrun}, 32'd0);
        for (int i = 1; i <= 4; i++) eb(0, 8'(i));
        m_ready = 1'b1;
        idle(8);
        chk("drain_empty", {31'd0, m_valid}, 32'd0);

`ifdef UART_RX_PKT_TIMEOUT_EN
        eb(0, 8'h11); exp_s.push_back({1'b0, 2'd3});
        send_byte(8'h7E); send_byte(8'h03); send_byte(8'h11);
        idle(20);
`endif

        // async reset mid-packet clears FIFO and returns FSM to HUNT
        m_ready = 1'b0;
        send_byte(8'h7E); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
        chk("pre_rst_valid", {31'd0, m_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, m_valid}, 32'd0);
        chk("midrst_outs", {19'd0, rx_clken, rx_rdy_clr, m_last, m_data, pkt_ok, pkt_err}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        m_ready = 1'b1;
        // csum 01^33 = 32
        eb(1, 8'h33); exp_s.push_back(3'b100);
        send_byte(8'h7E); send_byte(8'h01); send_byte(8'h33); send_byte(8'h32);
        idle(6);

        chk("exp_bytes_left", exp_b.size(), 32'd0);
        chk("exp_status_left", exp_s.size(), 32'd0);
        chk("rdy_clr_count", clr_seen, sent);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
